// File: rtl/gray_ptr_rx_if.sv
// gray_ptr_rx handshake bundle: source-side stimulus and tracked outputs.
// err_clr exists only when GRAY_PTR_RX_ERR_CLR_EN is defined.
interface gray_ptr_rx_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] gray_in;
  logic [DATA_WIDTH-1:0] bin_out;
  logic [DATA_WIDTH-1:0] delta;
  logic                  bin_valid;
  logic                  step_err;
  logic [7:0]            err_count;
`ifdef GRAY_PTR_RX_ERR_CLR_EN
  logic                  err_clr;

  modport master (
    output enable, gray_in, err_clr,
    input  bin_out, delta, bin_valid,
    input  step_err, err_count
  );

  modport slave (
    input  enable, gray_in, err_clr,
    output bin_out, delta, bin_valid,
    output step_err, err_count
  );
`else
  modport master (
    output enable, gray_in,
    input  bin_out, delta, bin_valid,
    input  step_err, err_count
  );

  modport slave (
    input  enable, gray_in,
    output bin_out, delta, bin_valid,
    output step_err, err_count
  );
`endif
endinterface

// File: rtl/gray_ptr_rx.sv
// Gray pointer receiver: sync, Gray->binary, delta, step check, lock FSM.
// Optional GRAY_PTR_RX_ERR_CLR_EN adds err_clr to clear err_count.
module gray_ptr_rx #(
  parameter int DATA_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          reset_n,
  gray_ptr_rx_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] INIT_LAST = CW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] g_s, gray_prev, diff, bin_c;
  logic [W-1:0] bin_q, delta_q;
  logic [7:0]   err_q;
  logic         step_q, err_det, illegal, err_clr;

  assign g_s  = sync_q[SYNC_STAGES-1];
  assign diff = g_s ^ gray_prev;
  // more than one bit set <=> clearing the lowest set bit leaves some
  assign illegal = |(diff & (diff - W'(1)));

`ifdef GRAY_PTR_RX_ERR_CLR_EN
  assign err_clr = bus.err_clr;
`else
  assign err_clr = 1'b0;
`endif

  always_comb begin
    bin_c = '0;
    for (int i = 0; i < W; i++) begin
      bin_c[i] = ^(g_s >> i);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_det  = 1'b0;
    if (!bus.enable) begin
      state_nx = INIT;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        INIT: begin
          if (cnt == INIT_LAST) begin
            state_nx = TRACK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        TRACK: begin
          if (illegal) begin
            err_det  = 1'b1;
            state_nx = RESYNC;
            cnt_nx   = '0;
          end
        end
        RESYNC: begin
          if (cnt == CW'(1)) begin
            state_nx = TRACK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = INIT;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      gray_prev <= '0;
      bin_q     <= '0;
      delta_q   <= '0;
      step_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.gray_in};
      gray_prev <= g_s;
      step_q    <= err_det;
      if (bus.enable) begin
        bin_q <= bin_c;
        if (state == TRACK) begin
          delta_q <= bin_c - bin_q;
        end else if (state == INIT) begin
          delta_q <= '0;
        end
      end
      // a clear coinciding with a pulse still counts that pulse
      if (err_clr) begin
        err_q <= {7'd0, step_q};
      end else if (step_q && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.delta     = delta_q;
  assign bus.bin_valid = (state == TRACK);
  assign bus.step_err  = step_q;
  assign bus.err_count = err_q;
endmodule

// File: doc/gray_ptr_rx.md
Name: gray_ptr_rx

Overview:
Receive-side stage for a Gray-coded count, e.g. a pointer from the graycounter producer running in a foreign clock domain. It synchronizes the Gray word into clk with a flop chain, converts it to binary, and reports the per-cycle increment. It checks that every observed change is a legal single-bit Gray step, and tracks lock state. It is the consumer that turns the producer's Gray output into usable binary pointer or rate information.

Parameters:
DATA_WIDTH, 4, width of Gray input and binary outputs (>=2)
SYNC_STAGES, 2, number of synchronizer flops on gray_in (>=2)

Ports:
clk  input  1  destination-domain clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = track; 0 = force INIT, hold outputs
gray_in  input  DATA_WIDTH  Gray count from the source domain (asynchronous)
bin_out  output  DATA_WIDTH  registered binary equivalent of the synchronized Gray value
delta  output  DATA_WIDTH  registered (bin_now - bin_prev) mod 2^DATA_WIDTH
bin_valid  output  1  1 when in TRACK; bin_out and delta are meaningful
step_err  output  1  one-cycle pulse: synchronized Gray changed by more than 1 bit
err_count  output  8  saturating count of step_err pulses

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk. All flops reset asynchronously; all other logic is on posedge clk.
- Reset values: sync chain 0, gray_prev 0, bin_out 0, delta 0, bin_valid 0, step_err 0, err_count 0, state INIT, init counter 0.
- Sync chain: SYNC_STAGES flops. g_s is the last stage and shifts every cycle regardless of enable or state.
- Conversion: b[W-1] = g_s[W-1]; b[i] = b[i+1] ^ g_s[i]. The result is registered into bin_out.
- Latency: a stable gray_in change appears on bin_out SYNC_STAGES+1 clocks after the first capturing edge.
- Step check: diff = g_s ^ gray_prev, where gray_prev is registered every cycle.
  - popcount(diff) is 0 or 1: legal.
  - popcount(diff) >= 2: step_err = 1 for exactly the next cycle, but only when state is TRACK.
- Delta: delta is registered as b - bin_out, modulo 2^W, computed every cycle in TRACK and held otherwise. Wrap example for W=4: 15 -> 0 gives delta 1.
- err_count increments on each step_err pulse and saturates at 255. It is cleared only by reset, or by err_clr when the optional feature is enabled.
- State machine, 2-bit encoding:
  - INIT: bin_valid = 0, no error checks. An internal counter runs SYNC_STAGES+1 cycles while enable = 1, then moves to TRACK. bin_out still updates in INIT; delta is held at 0.
  - TRACK: bin_valid = 1, checks active. If step_err fires, move to RESYNC.
  - RESYNC: bin_valid = 0 for exactly 2 cycles, then return to TRACK. bin_out keeps updating.
  - Any state, enable = 0: next state INIT, counter cleared, bin_out and delta held, step_err = 0.
- Simultaneous events:
  - enable falling on the same cycle as an illegal step: enable wins, so no step_err and no err_count increment.
  - Illegal step during RESYNC: ignored.
- reset_n asserted mid-operation: every register returns to its reset value immediately, without waiting for a clock. Tracking restarts at INIT after release.

Optional Feature:
GRAY_PTR_RX_ERR_CLR_EN
- Defined: adds input err_clr (1 bit). When err_clr = 1 on a cycle, err_count becomes 0 on the next edge. If err_clr coincides with a step_err pulse, the result is 1 (clear, then count).
- Undefined: no err_clr port; err_count is cleared only by reset.

Test Plan:
1. Reset released, enable = 1, gray_in = 0 -> bin_valid = 0 for the first SYNC_STAGES+1 cycles, then 1. bin_out = 0, delta = 0, err_count = 0.
2. gray_in driven as a Gray counter, advancing every 4 clk, W = 4 -> bin_out steps 0,1,...,15,0 with latency 3 (SYNC_STAGES = 2). delta = 1 on each step cycle, including the 15 -> 0 wrap (gray 1000 -> 0000). step_err is never asserted.
3. In TRACK with gray_in = 0000, jump to 0011 -> exactly one step_err pulse and err_count = 1. bin_valid low for 2 cycles, then high. bin_out = 2.
4. 300 illegal jumps, each separated by at least 4 cycles -> err_count saturates at 255 and stays there.
5. enable driven low for 5 cycles while in TRACK, gray_in changing -> bin_valid = 0 and bin_out held. After enable returns high, INIT lasts 3 cycles before TRACK.
6. reset_n pulsed low asynchronously between clk edges mid-count -> all outputs 0 immediately. With the macro defined, err_clr = 1 clears a non-zero err_count on the next edge.
